// File: rtl/pipelined_segmentation_adder.sv
// ----------------------------------------------------------------------------
// pipelined_segmentation_adder
//
// Adds two width-bit operands one segment per pipeline stage. Stage k+1 adds
// segment k of the operands. Each transaction carries its own copy of the
// operands, the partial sum, the segment carry, the mode and an error flag.
// It also carries a valid bit.
//
// Modes, captured per transaction:
//   exact  (approx_i=0) : each segment gets the registered carry out of the
//                         segment below it.
//   approx (approx_i=1) : every segment carry-in is forced to 0. A carry out
//                         of a lower segment is dropped and raises err_o.
//
// The pipeline moves as a single unit. It advances whenever the output is
// empty or the output is being taken. A stall freezes every stage.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-high reset
//   add1_i     : operand A (width)
//   add2_i     : operand B (width)
//   approx_i   : 1 = segmented approximate, 0 = exact
//   valid_i    : operands valid
//   ready_o    : block can accept operands this cycle
//   result_o   : sum (width+1); the MSB is the carry out of the top segment
//   err_o      : at least one inter-segment carry was dropped for this result
//   valid_o    : result_o / err_o valid
//   ready_i    : downstream accepts the result
//   err_cnt_o  : saturating count of delivered results with err_o=1
//   err_clr_i  : synchronous clear of err_cnt_o (has priority over increment)
// ----------------------------------------------------------------------------
module pipelined_segmentation_adder #(
    parameter int width     = 16,
    parameter int segment   = 4,
    parameter int cnt_width = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [width-1:0]     add1_i,
    input  logic [width-1:0]     add2_i,
    input  logic                 approx_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [width:0]       result_o,
    output logic                 err_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [cnt_width-1:0] err_cnt_o,
    input  logic                 err_clr_i
);

    localparam int nseg = width / segment;

    // Stage registers; index k holds the transaction after segment k is added.
    logic                 v_q [nseg];
    logic [width-1:0]     a_q [nseg];
    logic [width-1:0]     b_q [nseg];
    logic [width-1:0]     s_q [nseg];
    logic                 c_q [nseg];
    logic                 m_q [nseg];
    logic                 e_q [nseg];

    // Inputs to each stage. Stage 0 takes its inputs from the ports.
    logic                 in_v [nseg];
    logic [width-1:0]     in_a [nseg];
    logic [width-1:0]     in_b [nseg];
    logic [width-1:0]     in_s [nseg];
    logic                 in_c [nseg];
    logic                 in_m [nseg];
    logic                 in_e [nseg];

    // Values each stage will register.
    logic [segment:0]     seg_sum [nseg];
    logic [width-1:0]     nxt_s   [nseg];
    logic                 nxt_e   [nseg];

    logic advance;

    assign advance = !valid_o || ready_i;
    assign ready_o = advance;

    always_comb begin
        in_v[0] = valid_i;
        in_a[0] = add1_i;
        in_b[0] = add2_i;
        in_s[0] = '0;
        in_c[0] = 1'b0;
        in_m[0] = approx_i;
        in_e[0] = 1'b0;
        for (int k = 1; k < nseg; k++) begin
            in_v[k] = v_q[k-1];
            in_a[k] = a_q[k-1];
            in_b[k] = b_q[k-1];
            in_s[k] = s_q[k-1];
            in_c[k] = c_q[k-1];
            in_m[k] = m_q[k-1];
            in_e[k] = e_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < nseg; k++) begin
            seg_sum[k] = {1'b0, in_a[k][k*segment +: segment]}
                       + {1'b0, in_b[k][k*segment +: segment]}
                       + {{segment{1'b0}}, (in_m[k] ? 1'b0 : in_c[k])};
            nxt_s[k] = in_s[k];
            nxt_s[k][k*segment +: segment] = seg_sum[k][segment-1:0];
            // The top segment's carry becomes the result MSB, so it never
            // counts as a dropped carry.
            nxt_e[k] = in_e[k] | (in_m[k] & seg_sum[k][segment] & (k != nseg - 1));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < nseg; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                m_q[k] <= 1'b0;
                e_q[k] <= 1'b0;
            end
        end else if (advance) begin
            for (int k = 0; k < nseg; k++) begin
                v_q[k] <= in_v[k];
                a_q[k] <= in_a[k];
                b_q[k] <= in_b[k];
                s_q[k] <= nxt_s[k];
                c_q[k] <= seg_sum[k][segment];
                m_q[k] <= in_m[k];
                e_q[k] <= nxt_e[k];
            end
        end
    end

    assign valid_o  = v_q[nseg-1];
    assign result_o = {c_q[nseg-1], s_q[nseg-1]};
    assign err_o    = e_q[nseg-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_o <= '0;
        end else if (err_clr_i) begin
            err_cnt_o <= '0;
        end else if (valid_o && ready_i && err_o && (err_cnt_o != '1)) begin
            err_cnt_o <= err_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipelined_segmentation_adder.sv
// ----------------------------------------------------------------------------
// tb_pipelined_segmentation_adder
//
// Directed bench for pipelined_segmentation_adder with width=16, segment=4
// and cnt_width=4. It covers the following:
//   - reset state
//   - exact and approximate sums, including all-ones operands
//   - latency
//   - backpressure with stability checks
//   - counter saturation and clear priority
//   - reset while transactions are in flight
// ----------------------------------------------------------------------------
module tb_pipelined_segmentation_adder;

    localparam int W    = 16;
    localparam int SEG  = 4;
    localparam int CW   = 4;
    localparam int NSEG = W / SEG;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [W-1:0]  add1_i;
    logic [W-1:0]  add2_i;
    logic          approx_i;
    logic          valid_i;
    logic          ready_o;
    logic [W:0]    result_o;
    logic          err_o;
    logic          valid_o;
    logic          ready_i;
    logic [CW-1:0] err_cnt_o;
    logic          err_clr_i;

    int tests  = 0;
    int failed = 0;
    int exp_cnt = 0;

    logic [W-1:0] vec_a [$];
    logic [W-1:0] vec_b [$];
    logic         vec_m [$];

    pipelined_segmentation_adder #(.width(W), .segment(SEG), .cnt_width(CW)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .add1_i    (add1_i),
        .add2_i    (add2_i),
        .approx_i  (approx_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .result_o  (result_o),
        .err_o     (err_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .err_cnt_o (err_cnt_o),
        .err_clr_i (err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {err, result}. Exact mode is a plain add. Approximate mode adds
    // each nibble on its own, drops carries below the top nibble and flags
    // any carry that was dropped.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic m);
        logic [W:0]     r;
        logic           e;
        logic [SEG:0]   s;
        if (!m) return {1'b0, {1'b0, a} + {1'b0, b}};
        r = '0;
        e = 1'b0;
        for (int k = 0; k < NSEG; k++) begin
            s = {1'b0, a[k*SEG +: SEG]} + {1'b0, b[k*SEG +: SEG]};
            r[k*SEG +: SEG] = s[SEG-1:0];
            if (k == NSEG - 1) r[W] = s[SEG];
            else if (s[SEG]) e = 1'b1;
        end
        return {e, r};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Single transaction with ready_i=1. The result must appear after exactly
    // NSEG rising edges, counting the edge that accepts it.
    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                           input logic [W:0] exp_res, input logic exp_err, input string tag);
        ready_i  = 1'b1;
        add1_i   = a;
        add2_i   = b;
        approx_i = m;
        valid_i  = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (NSEG - 2) tick();
        chk({tag, "_early"}, {31'd0, valid_o}, 32'd0);
        tick();
        chk({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
        chk({tag, "_res"}, {15'd0, result_o}, {15'd0, exp_res});
        chk({tag, "_err"}, {31'd0, err_o}, {31'd0, exp_err});
        if (exp_err && exp_cnt < 15) exp_cnt++;
        tick();
    endtask

    // Streams the queued vectors back-to-back. ready_i is held low for the
    // first 'stall' cycles. While stalled, the output must keep showing the
    // oldest pending result.
    task automatic stream(input int stall, input string tag, output logic saw_low);
        int n_in  = 0;
        int n_out = 0;
        int cyc   = 0;
        logic [W+1:0] ex;
        saw_low = 1'b0;
        while (n_out < vec_a.size() && cyc < 300) begin
            ready_i = (cyc >= stall);
            #1;
            if (valid_o) begin
                ex = model(vec_a[n_out], vec_b[n_out], vec_m[n_out]);
                chk({tag, "_res"}, {15'd0, result_o}, {15'd0, ex[W:0]});
                chk({tag, "_err"}, {31'd0, err_o}, {31'd0, ex[W+1]});
                if (ready_i) begin
                    if (ex[W+1] && exp_cnt < 15) exp_cnt++;
                    n_out++;
                end
            end
            if (!ready_o) saw_low = 1'b1;
            if (n_in < vec_a.size()) begin
                add1_i   = vec_a[n_in];
                add2_i   = vec_b[n_in];
                approx_i = vec_m[n_in];
                valid_i  = 1'b1;
                if (ready_o) n_in++;
            end else begin
                valid_i = 1'b0;
            end
            tick();
            cyc++;
        end
        valid_i = 1'b0;
        chk({tag, "_count"}, n_out, vec_a.size());
    endtask

    logic low;

    initial begin
        rst_i     = 1'b1;
        add1_i    = '0;
        add2_i    = '0;
        approx_i  = 1'b0;
        valid_i   = 1'b0;
        ready_i   = 1'b1;
        err_clr_i = 1'b0;
        repeat (3) tick();
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_res", {15'd0, result_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_cnt", {28'd0, err_cnt_o}, 32'd0);
        rst_i = 1'b0;
        tick();
        chk("rst_ready", {31'd0, ready_o}, 32'd1);

        run_one(16'h00FF, 16'h0001, 1'b0, 17'h00100, 1'b0, "ex_ff1");
        run_one(16'h00FF, 16'h0001, 1'b1, 17'h000F0, 1'b1, "ap_ff1");
        run_one(16'hFFFF, 16'hFFFF, 1'b1, 17'h1EEEE, 1'b1, "ap_ffff");
        run_one(16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE, 1'b0, "ex_ffff");
        run_one(16'h1234, 16'h4321, 1'b1, 17'h05555, 1'b0, "ap_nocarry");
        run_one(16'h8000, 16'h8000, 1'b1, 17'h10000, 1'b0, "ap_topcarry");
        run_one(16'h0FFF, 16'h0001, 1'b0, 17'h01000, 1'b0, "ex_ripple");
        chk("cnt_after_dir", {28'd0, err_cnt_o}, 32'd2);

        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        exp_cnt = 0;
        chk("cnt_clr", {28'd0, err_cnt_o}, 32'd0);

        vec_a = '{16'h00FF, 16'h00FF, 16'hFFFF, 16'hFFFF, 16'h1234, 16'h0888};
        vec_b = '{16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF, 16'h0FED, 16'h0888};
        vec_m = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        stream(10, "bp", low);
        chk("bp_ready_low", {31'd0, low}, 32'd1);
        chk("bp_cnt", {28'd0, err_cnt_o}, 32'd3);

        vec_a.delete(); vec_b.delete(); vec_m.delete();
        for (int i = 0; i < 20; i++) begin
            vec_a.push_back(16'hFFFF);
            vec_b.push_back(16'hFFFF);
            vec_m.push_back(1'b1);
        end
        stream(0, "sat", low);
        chk("cnt_sat", {28'd0, err_cnt_o}, 32'd15);
        chk("cnt_sat_model", {28'd0, err_cnt_o}, exp_cnt);

        // Clear asserted in the same cycle as an error handshake.
        ready_i  = 1'b1;
        add1_i   = 16'hFFFF;
        add2_i   = 16'hFFFF;
        approx_i = 1'b1;
        valid_i  = 1'b1;
        tick();
        valid_i = 1'b0;
        repeat (NSEG - 1) tick();
        chk("clr_hs_valid", {31'd0, valid_o}, 32'd1);
        chk("clr_hs_err", {31'd0, err_o}, 32'd1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        chk("clr_priority", {28'd0, err_cnt_o}, 32'd0);

        // Reset asserted mid-flight, away from the clock edge.
        add1_i   = 16'h1111;
        add2_i   = 16'h2222;
        approx_i = 1'b0;
        valid_i  = 1'b1;
        repeat (3) tick();
        valid_i = 1'b0;
        tick();
        chk("pre_rst_valid", {31'd0, valid_o}, 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, valid_o}, 32'd0);
        chk("async_rst_res", {15'd0, result_o}, 32'd0);
        #2 rst_i = 1'b0;
        for (int i = 0; i < NSEG + 2; i++) begin
            tick();
            chk("post_rst_empty", {31'd0, valid_o}, 32'd0);
        end
        chk("post_rst_ready", {31'd0, ready_o}, 32'd1);
        run_one(16'h0F0F, 16'h0101, 1'b0, 17'h01010, 1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pipelined_segmentation_adder.md
PIPELINED_SEGMENTATION_ADDER -- requirements
Module: pipelined_segmentation_adder

Interface
REQ-001 SHALL have parameter width, default 16, operand width in bits.
REQ-002 SHALL have parameter segment, default 4, segment width in bits; width SHALL be a multiple of segment, with width >= segment.
REQ-003 SHALL have parameter cnt_width, default 16, error-counter width.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port add1_i  input  width  operand A.
REQ-007 SHALL have port add2_i  input  width  operand B.
REQ-008 SHALL have port approx_i  input  1  mode: 1 = segmented approximate, 0 = exact.
REQ-009 SHALL have port valid_i  input  1  operands valid.
REQ-010 SHALL have port ready_o  output  1  block can accept operands.
REQ-011 SHALL have port result_o  output  width+1  sum; MSB = carry out of top segment.
REQ-012 SHALL have port err_o  output  1  at least one inter-segment carry was dropped for this result.
REQ-013 SHALL have port valid_o  output  1  result_o/err_o valid.
REQ-014 SHALL have port ready_i  input  1  downstream accepts result.
REQ-015 SHALL have port err_cnt_o  output  cnt_width  count of delivered results with err_o=1.
REQ-016 SHALL have port err_clr_i  input  1  synchronous clear of err_cnt_o.

Function
REQ-017 SHALL split operands into NSEG = width/segment segments; segment k occupies bits [k*segment +: segment].
REQ-018 SHALL use an NSEG-stage pipeline; stage k+1 adds segment k, and each stage has its own valid bit.
REQ-019 In exact mode, SHALL feed each segment the registered carry out of the previous segment; segment 0 carry-in = 0.
REQ-020 In approximate mode, SHALL tie every segment carry-in to 0; carry out of segments 0..NSEG-2 SHALL be discarded.
REQ-021 SHALL capture approx_i with the operands and carry it through the pipeline; a mode change affects only newly accepted transactions.
REQ-022 SHALL carry the unprocessed operand bits and partial sums forward with each transaction through every stage.
REQ-023 SHALL set err_o to the OR of the discarded carries of segments 0..NSEG-2 in approximate mode, and to 0 in exact mode.
REQ-024 SHALL define advance = !valid_o | ready_i; when advance=1 all stages shift by one; when advance=0 all stages hold.
REQ-025 SHALL drive ready_o = advance; a transaction is accepted when valid_i & ready_o.
REQ-026 SHALL present a result exactly NSEG cycles after acceptance when no stall occurs; throughput SHALL be one transaction per cycle.
REQ-027 SHALL hold result_o, err_o and valid_o stable while valid_o=1 and ready_i=0.
REQ-028 SHALL deliver results in acceptance order with no loss or duplication under any ready_i pattern.
REQ-029 SHALL increment err_cnt_o on each output handshake (valid_o & ready_i) with err_o=1, saturating at 2^cnt_width-1.
REQ-030 When err_clr_i=1, err_cnt_o SHALL become 0 next cycle, overriding any simultaneous increment.
REQ-031 A bubble (valid_i=0 while advancing) SHALL propagate as an invalid stage and SHALL NOT affect err_cnt_o.

Reset
REQ-032 While rst_i=1, SHALL clear all stage valid bits and hold valid_o=0, result_o=0, err_o=0, err_cnt_o=0.
REQ-033 SHALL discard in-flight transactions when reset asserts mid-operation; after release the block SHALL be empty with ready_o=1.

Verification
REQ-034 Exact mode: width=16, segment=4, A=0x00FF, B=0x0001, ready_i=1 -> result_o=0x00100 and err_o=0 after 4 cycles.
REQ-035 Approximate mode, same operands -> result_o=0x000F0 and err_o=1. Operands 0xFFFF+0xFFFF -> 0x1EEEE with err_o=1 in approximate mode, and 0x1FFFE with err_o=0 in exact mode.
REQ-036 Backpressure: ready_i=0 while 6 back-to-back transactions with alternating mode are offered -> ready_o falls once the pipe is full; valid_o and result_o stay stable; after ready_i=1 all 6 results arrive in order and match the reference model.
REQ-037 Counter: cnt_width=4, 20 delivered err_o=1 results -> err_cnt_o=15; err_clr_i pulsed together with an error handshake -> err_cnt_o=0.
REQ-038 Reset mid-operation: 3 transactions in flight, rst_i pulsed asynchronously between clock edges -> valid_o=0 immediately; no stale result appears after release; the next transaction completes with latency NSEG.
